mux_nx1_rr_reg: RTL and testbench
=================================

// Module: mux_nx1_rr_reg
// PURPOSE
//  Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshake on every port.
//  Next generation of the 32-bit 2:1 mux in the ALU datapath.
//  Selection is either software-driven (select port) or round-robin arbitration among valid inputs.
//  Feeds ALU operand/result buses where several producers share one consumer.
// PARAMETERS
//  WIDTH  32  data width per channel, >=1
//  N      4   number of input channels, >=2
//  MODE   0   0 = MODE_SEL (grant = select port), 1 = MODE_RR (round-robin over in_valid)
//  SELW   $clog2(N)  localparam, width of select/out_sel
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N        channel i holds a word
//  in_ready   out  N        channel i word accepted this cycle (one-hot or zero)
//  select     in   SELW     channel index, used only when MODE=0
//  out        out  WIDTH    registered output word
//  out_valid  out  1        out holds a word
//  out_ready  in   1        consumer accepts out this cycle
//  out_sel    out  SELW     index of the channel that produced out
// BEHAVIOUR
//  - Reset (rst=1 at posedge) forces out=0, out_valid=0, out_sel=0, and rr_ptr=N-1.
//    The first RR search therefore starts at channel 0.
//  - Reset overrides all traffic. A word held in out is discarded; in_ready is 0 during reset cycles.
//  - load = !out_valid || out_ready. The output register accepts a new word only when load=1.
//  - Grant, combinational:
//    - MODE 0: gnt_valid = (select<N) && in_valid[select]; gnt = select.
//    - MODE 1: gnt = first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo N (wraps N-1 -> 0).
//      gnt_valid = |in_valid.
//  - in_ready[gnt] = load && gnt_valid. All other in_ready bits are 0.
//    in_ready does not depend on in_data.
//  - Transfer in: when load && gnt_valid at a posedge, out <= in_data[gnt], out_sel <= gnt, out_valid <= 1.
//    In MODE 1, rr_ptr <= gnt.
//  - Drain: when load && !gnt_valid, out_valid <= 0. out and out_sel hold their old values. rr_ptr is unchanged.
//  - Stall: when out_valid && !out_ready, out, out_sel, out_valid and rr_ptr all hold; in_ready = 0.
//  - Latency is 1 cycle from input acceptance to out_valid.
//  - Throughput is 1 word per cycle when out_ready is held at 1. A simultaneous consume and refill is a single cycle.
//  - rr_ptr advances only on an accepted transfer. A stalled grant never moves the pointer.
//  - MODE 0 with select>=N (N not a power of 2) gives no grant and no in_ready.
//  - A change of select while stalled has no effect until load=1.
//  - A sole requester is granted every cycle, back-to-back.
//  - With all N channels valid, grants cycle 0,1,..,N-1,0 with no starvation.
//    Any valid channel is granted within N accepted transfers.
//  - Nothing in this block overflows: no arithmetic beyond the modulo-N pointer wrap.
// STRUCTURE
//  - Shared package mux_pkg (mux_pkg.vh) holds:
//    - MODE_SEL=0 and MODE_RR=1 constants.
//    - The clog2 helper used for SELW.
//  - Sub-module rr_grant_nx1 (params N, SELW): purely combinational.
//    - Inputs: req[N] and ptr[SELW].
//    - Outputs: gnt[SELW] and gnt_valid.
//    - Computes the rotate-priority search.
//  - The top level holds the output register, the out_valid flag, rr_ptr, mode selection and in_ready decode.
// TESTING (bench mux_nx1_rr_reg_tb, WIDTH=32, N=4)
//  1. Reset.
//     - Stimulus: rst=1 for 2 cycles while in_valid=4'b1111.
//     - Response: out=0, out_valid=0, out_sel=0, in_ready=0.
//  2. MODE 0 select.
//     - Stimulus: select=2, in_valid=4'b0100, ch2=32'h12345678, out_ready=1.
//     - Response: in_ready=4'b0100. Next cycle out=32'h12345678, out_valid=1, out_sel=2.
//     - Then select=3 with in_valid[3]=0 -> out_valid=0 one cycle later.
//  3. MODE 1 fairness.
//     - Stimulus: all 4 valid with ch_i=32'hA000000i, out_ready=1 for 8 cycles.
//     - Response: out_sel sequence is 0,1,2,3,0,1,2,3.
//     - out follows: A0000000, A0000001, ...
//  4. Backpressure.
//     - Stimulus: MODE 1, out_ready=0 for 3 cycles after out=32'hFFFFFFFF.
//     - Response: out and out_sel are stable, in_ready=0, rr_ptr is frozen.
//     - Stimulus: release out_ready.
//     - Response: the next grant resumes at ptr+1.
//  5. Sparse and wrap.
//     - Stimulus: MODE 1, rr_ptr=3, in_valid=4'b0010.
//     - Response: gnt=1 and the pointer moves to 1.
//     - Stimulus: in_valid=4'b0011 next.
//     - Response: gnt=0 (wrapped search 2,3,0).
//  6. Reset mid-stream.
//     - Stimulus: assert rst while out_valid=1 and out_ready=0.
//     - Response: out_valid=0 and out=0 next cycle.
//     - After reset, the first RR grant goes to channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 multiplexer family.
//   mux_mode_e : grant source selection (software select or round-robin)
//   clog2      : ceiling log2, used to size channel index ports
package mux_pkg;

  typedef enum int unsigned {
    MODE_SEL = 0,
    MODE_RR  = 1
  } mux_mode_e;

  // Ceiling log2 for n >= 2; usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_grant_nx1.sv
// Combinational rotate-priority search for round-robin arbitration.
//   req       in   N     request vector, one bit per channel
//   ptr       in   SELW  last granted channel; search starts at ptr+1
//   gnt       out  SELW  first requesting channel found, modulo-N wrap
//   gnt_valid out  1     at least one request present
module rr_grant_nx1 #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt,
  output logic            gnt_valid
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;

  // Doubling the request vector turns the modulo-N rotation into a plain
  // right shift: rot[j] is the request of channel (ptr+1+j) mod N.
  always_comb begin
    req2      = {req, req};
    rot       = N'(req2 >> (32'(ptr) + 32'd1));
    gnt       = '0;
    gnt_valid = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!gnt_valid && rot[j]) begin
        gnt       = SELW'((32'(ptr) + 32'd1 + j) % N);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_rr_reg.sv
// Registered N-input multiplexer with valid/ready on every port.
// Grant comes from the select port (MODE_SEL) or round-robin over in_valid
// (MODE_RR). One word per cycle when out_ready stays high.
//   clk, rst   rising-edge clock, synchronous active-high reset
//   in_data    N*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   N, channel i holds a word
//   in_ready   N, one-hot (or zero) acceptance this cycle
//   select     SELW, channel index, used only in MODE_SEL
//   out        WIDTH, registered output word
//   out_valid  out holds a word
//   out_ready  consumer accepts out this cycle
//   out_sel    SELW, channel that produced out
module mux_nx1_rr_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = 0,
  localparam int SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      select,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);

  logic [WIDTH-1:0] out_q, out_d, data_sel;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0]  gnt, rr_gnt;
  logic             gnt_valid, rr_gnt_valid;
  logic             load, take;

  rr_grant_nx1 #(
    .N   (N),
    .SELW(SELW)
  ) u_rr_grant (
    .req      (in_valid),
    .ptr      (rr_ptr_q),
    .gnt      (rr_gnt),
    .gnt_valid(rr_gnt_valid)
  );

  always_comb begin
    if (MODE == int'(MODE_RR)) begin
      gnt       = rr_gnt;
      gnt_valid = rr_gnt_valid;
    end else begin
      gnt       = select;
      // Out-of-range select (N not a power of two) never grants.
      gnt_valid = (32'(select) < 32'(N)) && in_valid[select];
    end
  end

  assign load = !out_valid_q || out_ready;
  assign take = load && gnt_valid && !rst;

  always_comb begin
    in_ready = '0;
    data_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) begin
        in_ready[i] = take;
        data_sel    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (gnt_valid) begin
        out_d       = data_sel;
        out_sel_d   = gnt;
        out_valid_d = 1'b1;
        if (MODE == int'(MODE_RR)) begin
          rr_ptr_d = gnt;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      // Pointer parked on the last channel so the first search starts at 0.
      rr_ptr_q    <= SELW'(N - 1);
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// Bench for mux_nx1_rr_reg: a MODE_SEL and a MODE_RR instance (WIDTH=32,
// N=4) tracked by a reference model, plus an N=3 MODE_SEL instance for the
// out-of-range select case.
module tb_mux_nx1_rr_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] din  [2];
  logic [3:0]   vin  [2];
  logic [3:0]   rdy  [2];
  logic [1:0]   sel  [2];
  logic [31:0]  dout [2];
  logic         dval [2];
  logic         ordy [2];
  logic [1:0]   dsel [2];

  logic [23:0]  d3;
  logic [2:0]   v3, r3;
  logic [1:0]   s3, os3;
  logic [7:0]   o3;
  logic         ov3, or3;

  mux_nx1_rr_reg #(.WIDTH(32), .N(4), .MODE(0)) dut_sel (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
    .select(sel[0]), .out(dout[0]), .out_valid(dval[0]), .out_ready(ordy[0]),
    .out_sel(dsel[0]));

  mux_nx1_rr_reg #(.WIDTH(32), .N(4), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
    .select(sel[1]), .out(dout[1]), .out_valid(dval[1]), .out_ready(ordy[1]),
    .out_sel(dsel[1]));

  mux_nx1_rr_reg #(.WIDTH(8), .N(3), .MODE(0)) dut_n3 (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3),
    .select(s3), .out(o3), .out_valid(ov3), .out_ready(or3), .out_sel(os3));

  int errors = 0;
  int checks = 0;

  // Reference state: what the output register should hold per instance.
  logic [31:0] m_out [2];
  logic        m_val [2];
  int          m_sel [2];
  int          m_ptr [2];
  bit          m_known = 1'b0;

  typedef struct {
    int         d;
    logic [3:0] v;
    logic [1:0] s;
    logic       ordy;
    logic [3:0] erdy;
    logic       eov;
    logic [1:0] eos;
    logic [31:0] eout;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Granted channel or -1. Round-robin: lowest valid index above the last
  // grant, otherwise the lowest valid index overall.
  function automatic int pick(int d, logic [3:0] v, int s, int ptr);
    int lo, hi;
    lo = -1;
    hi = -1;
    if (d == 0) return (s < 4 && v[s]) ? s : -1;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) begin
        lo = i;
        if (i > ptr) hi = i;
      end
    end
    return (hi >= 0) ? hi : lo;
  endfunction

  // One clock: compare against the model, cross the edge, advance the model.
  task automatic step();
    int         g  [2];
    bit         ld [2];
    logic [3:0] er;
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d]  = pick(d, vin[d], int'(sel[d]), m_ptr[d]);
      ld[d] = !m_val[d] || ordy[d];
      er    = (!rst && ld[d] && g[d] >= 0) ? 4'(1 << g[d]) : 4'b0;
      chk(d == 0 ? "model.sel.in_ready" : "model.rr.in_ready", 32'(rdy[d]), 32'(er));
      if (m_known) begin
        chk(d == 0 ? "model.sel.out_valid" : "model.rr.out_valid", 32'(dval[d]), 32'(m_val[d]));
        chk(d == 0 ? "model.sel.out" : "model.rr.out", dout[d], m_out[d]);
        chk(d == 0 ? "model.sel.out_sel" : "model.rr.out_sel", 32'(dsel[d]), 32'(m_sel[d]));
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_out[d] = '0;
        m_val[d] = 1'b0;
        m_sel[d] = 0;
        m_ptr[d] = 3;
      end else if (ld[d]) begin
        if (g[d] >= 0) begin
          m_out[d] = din[d][g[d]*32 +: 32];
          m_sel[d] = g[d];
          m_val[d] = 1'b1;
          if (d == 1) m_ptr[d] = g[d];
        end else begin
          m_val[d] = 1'b0;
        end
      end
    end
    if (rst) m_known = 1'b1;
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_out[d] = '0;
      m_val[d] = 1'b0;
      m_sel[d] = 0;
      m_ptr[d] = 3;
      vin[d]   = 4'hF;
      ordy[d]  = 1'b1;
      sel[d]   = 2'd0;
    end
    din[0] = {32'hA0000003, 32'h12345678, 32'hA0000001, 32'hA0000000};
    din[1] = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    d3  = 24'hC3B2A1;
    v3  = 3'b111;
    s3  = 2'd0;
    or3 = 1'b1;
    rst = 1'b1;

    // Reset with every channel requesting.
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk("reset.out", dout[d], 32'h0);
      chk("reset.out_valid", 32'(dval[d]), 32'h0);
      chk("reset.out_sel", 32'(dsel[d]), 32'h0);
    end
    chk("reset.n3.in_ready", 32'(r3), 32'h0);
    rst    = 1'b0;
    vin[0] = 4'h0;
    vin[1] = 4'h0;

    // N=3: select beyond the last channel grants nothing.
    s3 = 2'd3;
    #1 chk("n3.sel_oob.in_ready", 32'(r3), 32'h0);
    step();
    chk("n3.sel_oob.out_valid", 32'(ov3), 32'h0);
    s3 = 2'd2;
    #1 chk("n3.sel2.in_ready", 32'(r3), 32'h4);
    step();
    chk("n3.sel2.out_valid", 32'(ov3), 32'h1);
    chk("n3.sel2.out_sel", 32'(os3), 32'h2);
    chk("n3.sel2.out", 32'(o3), 32'hC3);
    v3 = 3'b000;

    // Directed vectors: {dut, valid, select, out_ready, exp in_ready, exp out_valid/out_sel/out}
    tbl.push_back('{0, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h12345678});
    tbl.push_back('{0, 4'b0000, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd2, 32'h12345678});
    tbl.push_back('{0, 4'b1111, 2'd1, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA0000001});
    tbl.push_back('{0, 4'b1111, 2'd3, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA0000001});
    tbl.push_back('{0, 4'b1111, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA0000001});
    tbl.push_back('{0, 4'b1111, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0000000});
    tbl.push_back('{0, 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0000000});
    for (int k = 0; k < 8; k++) begin
      tbl.push_back('{1, 4'b1111, 2'd0, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4),
                      32'hA0000000 + 32'(k % 4)});
    end
    foreach (tbl[i]) begin
      vin[0]  = 4'h0;
      vin[1]  = 4'h0;
      ordy[0] = 1'b1;
      ordy[1] = 1'b1;
      sel[0]  = 2'd0;
      vin[tbl[i].d]  = tbl[i].v;
      ordy[tbl[i].d] = tbl[i].ordy;
      if (tbl[i].d == 0) sel[0] = tbl[i].s;
      #1 chk("tbl.in_ready", 32'(rdy[tbl[i].d]), 32'(tbl[i].erdy));
      step();
      chk("tbl.out_valid", 32'(dval[tbl[i].d]), 32'(tbl[i].eov));
      chk("tbl.out_sel", 32'(dsel[tbl[i].d]), 32'(tbl[i].eos));
      chk("tbl.out", dout[tbl[i].d], tbl[i].eout);
    end
    vin[0] = 4'h0;

    // Backpressure on the round-robin instance: freeze, then resume at ptr+1.
    din[1][63:32] = 32'hFFFFFFFF;
    vin[1]  = 4'b0010;
    ordy[1] = 1'b1;
    #1 chk("bp.load.in_ready", 32'(rdy[1]), 32'h2);
    step();
    chk("bp.load.out", dout[1], 32'hFFFFFFFF);
    vin[1]  = 4'b1111;
    ordy[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp.stall.in_ready", 32'(rdy[1]), 32'h0);
      step();
      chk("bp.stall.out", dout[1], 32'hFFFFFFFF);
      chk("bp.stall.out_sel", 32'(dsel[1]), 32'h1);
      chk("bp.stall.out_valid", 32'(dval[1]), 32'h1);
    end
    ordy[1] = 1'b1;
    #1 chk("bp.resume.in_ready", 32'(rdy[1]), 32'h4);
    step();
    chk("bp.resume.out_sel", 32'(dsel[1]), 32'h2);

    // Sparse requests and search wrap from pointer 3.
    vin[1] = 4'b1000;
    step();
    vin[1] = 4'b0010;
    #1 chk("wrap.sparse.in_ready", 32'(rdy[1]), 32'h2);
    step();
    chk("wrap.sparse.out_sel", 32'(dsel[1]), 32'h1);
    vin[1] = 4'b0011;
    #1 chk("wrap.search.in_ready", 32'(rdy[1]), 32'h1);
    step();
    chk("wrap.search.out_sel", 32'(dsel[1]), 32'h0);
    chk("wrap.search.out", dout[1], 32'hA0000000);

    // Reset while a word is held under backpressure.
    vin[1]  = 4'b0100;
    ordy[1] = 1'b0;
    step();
    rst = 1'b1;
    #1 chk("midrst.in_ready", 32'(rdy[1]), 32'h0);
    step();
    chk("midrst.out_valid", 32'(dval[1]), 32'h0);
    chk("midrst.out", dout[1], 32'h0);
    rst     = 1'b0;
    vin[1]  = 4'b1111;
    ordy[1] = 1'b1;
    #1 chk("midrst.first.in_ready", 32'(rdy[1]), 32'h1);
    step();
    chk("midrst.first.out_sel", 32'(dsel[1]), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        din[d]  = {$urandom, $urandom, $urandom, $urandom};
        vin[d]  = 4'($urandom_range(0, 15));
        sel[d]  = 2'($urandom_range(0, 3));
        ordy[d] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
